// File: rtl/galvo_pkg.sv
// Shared definitions for the galvo point streamer: FSM state encoding,
// MCP4922-style DAC control bits and the 16-bit frame builder.
package galvo_pkg;

    localparam int DATA_W  = 12;
    localparam int FRAME_W = 16;

    // DAC control bits carried in the top nibble of every frame
    localparam logic CH_X   = 1'b0;
    localparam logic CH_Y   = 1'b1;
    localparam logic BUF    = 1'b0;
    localparam logic GA_N   = 1'b1;
    localparam logic SHDN_N = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT_X = 3'd1,
        ST_GAP     = 3'd2,
        ST_SHIFT_Y = 3'd3,
        ST_LATCH   = 3'd4
    } state_t;

    // Build one DAC write word: {ch, BUF, GA_n, SHDN_n, code}
    function automatic logic [FRAME_W-1:0] dac_frame(input logic ch,
                                                     input logic [DATA_W-1:0] code);
        return {ch, BUF, GA_N, SHDN_N, code};
    endfunction

endpackage

// File: rtl/galvo_point_streamer_if.sv
// Point FIFO handshake between the upstream FIFO (master) and the streamer (slave).
interface galvo_point_streamer_if;
    import galvo_pkg::*;

    logic              pt_valid;
    logic [DATA_W-1:0] pt_x;
    logic [DATA_W-1:0] pt_y;
    logic              pt_laser;
    logic              pt_ready;

    modport master (output pt_valid, pt_x, pt_y, pt_laser, input pt_ready);
    modport slave  (input pt_valid, pt_x, pt_y, pt_laser, output pt_ready);

endinterface

// File: rtl/galvo_point_streamer_spi_frame_tx.sv
// SPI mode-0 transmitter for one 16-bit frame, MSB first. Each SCLK phase
// lasts CLK_DIV clocks; mosi changes at the start of each low phase. done is
// asserted combinationally in the final cycle of the last high phase so the
// owner can raise chip select on the very next cycle.
module spi_frame_tx
    import galvo_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] word,
    output logic               sclk,
    output logic               mosi,
    output logic               done
);

    localparam int               CNT_W    = 8;
    localparam int               BIT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic               active;
    logic               high_phase;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    // bits still to be sent after the one currently on mosi
    logic [FRAME_W-2:0] shreg;

    assign done = active && high_phase && (div_cnt == DIV_LAST) && (bit_cnt == '0);

    // Phase divider, bit counter and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
        end else if (start) begin
            active     <= 1'b1;
            high_phase <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= BIT_W'(FRAME_W - 1);
            shreg      <= word[FRAME_W-2:0];
            sclk       <= 1'b0;
            mosi       <= word[FRAME_W-1];
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (!high_phase) begin
                    high_phase <= 1'b1;
                    sclk       <= 1'b1;
                end else begin
                    high_phase <= 1'b0;
                    sclk       <= 1'b0;
                    if (bit_cnt == '0) begin
                        // frame finished: park the data line low
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        mosi    <= shreg[FRAME_W-2];
                        shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/galvo_point_streamer.sv
// Galvo point streamer: on each accepted update strobe pops one point from
// the FIFO, writes X then Y to a dual 12-bit SPI DAC and pulses LDAC so both
// axes and the laser gate update together.
// Optional build macro BLANK_ON_UNDERRUN_EN: when defined, a strobe that finds
// the FIFO empty also turns the laser off on the following cycle.
module galvo_point_streamer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  strobe_in,
    galvo_point_streamer_if.slave pt,
    output logic                  dac_cs_n,
    output logic                  dac_sclk,
    output logic                  dac_mosi,
    output logic                  dac_ldac_n,
    output logic                  laser_on,
    output logic                  busy,
    output logic [7:0]            underrun_count
);
    import galvo_pkg::*;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t             state;
    logic [7:0]         phase_cnt;
    logic [DATA_W-1:0]  y_lat;
    logic               laser_lat;

    logic               accept;
    logic               underrun;
    logic               gap_end;
    logic               spi_start;
    logic               spi_done;
    logic [FRAME_W-1:0] spi_word;

    assign pt.pt_ready = (state == ST_IDLE) && strobe_in;
    assign accept      = pt.pt_ready && pt.pt_valid;
    assign underrun    = pt.pt_ready && !pt.pt_valid;
    assign gap_end     = (state == ST_GAP) && (phase_cnt == PHASE_LAST);

    // X is loaded straight from the FIFO in the accept cycle, Y from its latch
    assign spi_start = accept || gap_end;
    assign spi_word  = accept ? dac_frame(CH_X, pt.pt_x) : dac_frame(CH_Y, y_lat);

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (spi_start),
        .word  (spi_word),
        .sclk  (dac_sclk),
        .mosi  (dac_mosi),
        .done  (spi_done)
    );

    // Transaction FSM with registered chip select, LDAC, laser and underrun count
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            dac_cs_n       <= 1'b1;
            dac_ldac_n     <= 1'b1;
            laser_on       <= 1'b0;
            busy           <= 1'b0;
            underrun_count <= '0;
            phase_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHIFT_X;
                        dac_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        y_lat     <= pt.pt_y;
                        laser_lat <= pt.pt_laser;
                    end else if (underrun) begin
                        if (underrun_count != 8'hFF) begin
                            underrun_count <= underrun_count + 1'b1;
                        end
`ifdef BLANK_ON_UNDERRUN_EN
                        laser_on <= 1'b0;
`else
                        laser_on <= laser_on;
`endif
                    end
                end
                ST_SHIFT_X: begin
                    if (spi_done) begin
                        state     <= ST_GAP;
                        dac_cs_n  <= 1'b1;
                        phase_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == PHASE_LAST) begin
                        state    <= ST_SHIFT_Y;
                        dac_cs_n <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_SHIFT_Y: begin
                    if (spi_done) begin
                        state      <= ST_LATCH;
                        dac_cs_n   <= 1'b1;
                        dac_ldac_n <= 1'b0;
                        laser_on   <= laser_lat;
                        phase_cnt  <= '0;
                    end
                end
                ST_LATCH: begin
                    if (phase_cnt == PHASE_LAST) begin
                        state      <= ST_IDLE;
                        dac_ldac_n <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_galvo_point_streamer.sv
// Bench for galvo_point_streamer: two instances (CLK_DIV=4 and CLK_DIV=2),
// randomized points checked cycle by cycle against a timeline model.
module tb_galvo_point_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic strobe_a, strobe_b;
    logic cs_a, sclk_a, mosi_a, ldac_a, laser_a, busy_a;
    logic cs_b, sclk_b, mosi_b, ldac_b, laser_b, busy_b;
    logic [7:0] under_a, under_b;

    galvo_point_streamer_if pt_a ();
    galvo_point_streamer_if pt_b ();

    galvo_point_streamer #(.CLK_DIV(4), .DATA_W(12)) dut_a (
        .clk(clk), .reset(reset), .strobe_in(strobe_a), .pt(pt_a),
        .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .dac_ldac_n(ldac_a),
        .laser_on(laser_a), .busy(busy_a), .underrun_count(under_a));

    galvo_point_streamer #(.CLK_DIV(2), .DATA_W(12)) dut_b (
        .clk(clk), .reset(reset), .strobe_in(strobe_b), .pt(pt_b),
        .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .dac_ldac_n(ldac_b),
        .laser_on(laser_b), .busy(busy_b), .underrun_count(under_b));

    // selected instance for observation
    int sel = 0;
    logic o_cs, o_sclk, o_mosi, o_ldac, o_laser, o_busy, o_ready;
    logic [7:0] o_under;
    always_comb begin
        if (sel == 0) begin
            o_cs = cs_a; o_sclk = sclk_a; o_mosi = mosi_a; o_ldac = ldac_a;
            o_laser = laser_a; o_busy = busy_a; o_ready = pt_a.pt_ready; o_under = under_a;
        end else begin
            o_cs = cs_b; o_sclk = sclk_b; o_mosi = mosi_b; o_ldac = ldac_b;
            o_laser = laser_b; o_busy = busy_b; o_ready = pt_b.pt_ready; o_under = under_b;
        end
    end

    // SPI decoder: DAC samples mosi on sclk rise while cs_n is low
    logic [15:0] rx_sh;
    int          rx_bits = 0;
    logic [31:0] rx_q[$];
    realtime     ldac_t[$];
    int          cs_falls = 0;
    always @(posedge o_sclk) if (!o_cs) begin
        rx_sh   <= {rx_sh[14:0], o_mosi};
        rx_bits <= rx_bits + 1;
    end
    always @(posedge o_cs) begin
        rx_q.push_back({16'(rx_bits), rx_sh});
        rx_bits <= 0;
    end
    always @(negedge o_cs) cs_falls <= cs_falls + 1;
    always @(negedge o_ldac) ldac_t.push_back($realtime);

    // FIFO pop counters
    int pops_a = 0, pops_b = 0;
    always @(posedge clk) begin
        if (pt_a.pt_ready && pt_a.pt_valid) pops_a <= pops_a + 1;
        if (pt_b.pt_ready && pt_b.pt_valid) pops_b <= pops_b + 1;
    end

    // reference model state
    logic mdl_laser[2];
    int   mdl_under[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic stb, input logic vld,
                         input logic [11:0] x, input logic [11:0] y, input logic l);
        if (s == 0) begin
            strobe_a = stb; pt_a.pt_valid = vld; pt_a.pt_x = x; pt_a.pt_y = y; pt_a.pt_laser = l;
        end else begin
            strobe_b = stb; pt_b.pt_valid = vld; pt_b.pt_x = x; pt_b.pt_y = y; pt_b.pt_laser = l;
        end
    endtask

    // One full accepted transaction on the selected instance; optional stray
    // strobe at cycle inj (0 = none). Every cycle is compared to the timeline.
    task automatic run_txn(input logic [11:0] x, input logic [11:0] y, input logic l, input int inj);
        int d, last, o, p0, p1, u0;
        logic [15:0] fx, fy, f;
        logic e_cs, e_sclk, e_mosi, e_ldac, e_busy, e_las, las0;
        d    = (sel == 0) ? 4 : 2;
        last = 66 * d;
        fx   = {1'b0, 1'b0, 1'b1, 1'b1, x};
        fy   = {1'b1, 1'b0, 1'b1, 1'b1, y};
        p0   = (sel == 0) ? pops_a : pops_b;
        u0   = mdl_under[sel];
        las0 = mdl_laser[sel];
        drive(sel, 1'b1, 1'b1, x, y, l);
        #1;
        check("ready_accept", 32'(o_ready), 32'd1);
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            drive(sel, (c == inj), 1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
            if (c == inj) begin
                #1;
                check($sformatf("ready_busy@%0d", c), 32'(o_ready), 32'd0);
            end
            e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_ldac = 1'b1;
            e_busy = (c <= last); e_las = las0;
            f = fx; o = -1;
            if (c >= 1 && c <= 32 * d) begin
                f = fx; o = c - 1;
            end else if (c >= 33 * d + 1 && c <= 65 * d) begin
                f = fy; o = c - (33 * d + 1);
            end
            if (o >= 0) begin
                e_cs   = 1'b0;
                e_sclk = 1'((o / d) % 2);
                e_mosi = f[15 - o / (2 * d)];
            end
            if (c >= 65 * d + 1 && c <= 66 * d) e_ldac = 1'b0;
            if (c >= 65 * d + 1) e_las = l;
            check($sformatf("cs_n@%0d", c),   32'(o_cs),    32'(e_cs));
            check($sformatf("sclk@%0d", c),   32'(o_sclk),  32'(e_sclk));
            check($sformatf("mosi@%0d", c),   32'(o_mosi),  32'(e_mosi));
            check($sformatf("ldac_n@%0d", c), 32'(o_ldac),  32'(e_ldac));
            check($sformatf("busy@%0d", c),   32'(o_busy),  32'(e_busy));
            check($sformatf("laser@%0d", c),  32'(o_laser), 32'(e_las));
        end
        mdl_laser[sel] = l;
        p1 = (sel == 0) ? pops_a : pops_b;
        check("pops_per_txn", 32'(p1 - p0), 32'd1);
        check("under_hold", 32'(o_under), 32'(u0));
        check("frame_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check("frame_x", rx_q.pop_front(), {16'd16, fx});
            check("frame_y", rx_q.pop_front(), {16'd16, fy});
        end
        rx_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, cf0, lt0;
        logic [11:0] qx[$], qy[$];
        logic        ql[$];

        // reset state
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
        repeat (3) tick();
        check("rst_cs_n",  32'(o_cs),    32'd1);
        check("rst_sclk",  32'(o_sclk),  32'd0);
        check("rst_mosi",  32'(o_mosi),  32'd0);
        check("rst_ldac",  32'(o_ldac),  32'd1);
        check("rst_laser", 32'(o_laser), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_under", 32'(o_under), 32'd0);
        reset = 1'b0;
        tick();
        rx_q.delete();
        mdl_laser[0] = 1'b0; mdl_laser[1] = 1'b0;
        mdl_under[0] = 0;    mdl_under[1] = 0;

        // single point with known codes
        run_txn(12'hABC, 12'h123, 1'b1, 0);

        // reset held 3 cycles in the middle of the X frame
        drive(0, 1'b1, 1'b1, 12'h555, 12'h2AA, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
        repeat (49) tick();
        check("mid_busy", 32'(o_busy), 32'd1);
        n0 = ldac_t.size();
        reset = 1'b1;
        tick();
        check("abort_cs_n",  32'(o_cs),    32'd1);
        check("abort_ldac",  32'(o_ldac),  32'd1);
        check("abort_laser", 32'(o_laser), 32'd0);
        check("abort_busy",  32'(o_busy),  32'd0);
        check("abort_sclk",  32'(o_sclk),  32'd0);
        tick();
        tick();
        reset = 1'b0;
        mdl_laser[0] = 1'b0; mdl_laser[1] = 1'b0;
        mdl_under[0] = 0;    mdl_under[1] = 0;
        repeat (300) tick();
        check("abort_no_ldac", 32'(ldac_t.size()), 32'(n0));
        check("abort_idle_cs", 32'(o_cs), 32'd1);
        rx_q.delete();

        // stray strobes during transactions
        run_txn(12'($urandom), 12'($urandom), 1'b0, 100);
        for (int i = 0; i < 3; i++) begin
            run_txn(12'($urandom), 12'($urandom), 1'($urandom), $urandom_range(1, 264));
            repeat ($urandom_range(0, 20)) tick();
        end

        // underrun: laser on first, then 300 strobes into an empty FIFO
        run_txn(12'($urandom), 12'($urandom), 1'b1, 0);
        cf0 = cs_falls;
        drive(0, 1'b1, 1'b0, 12'h0, 12'h0, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
        mdl_under[0] = mdl_under[0] + 1;
`ifdef BLANK_ON_UNDERRUN_EN
        mdl_laser[0] = 1'b0;
`endif
        check("under_first", 32'(o_under), 32'(mdl_under[0]));
        check("under_laser", 32'(o_laser), 32'(mdl_laser[0]));
        for (int i = 1; i < 300; i++) begin
            drive(0, 1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'($urandom));
            tick();
            drive(0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
            tick();
            if (mdl_under[0] < 255) mdl_under[0] = mdl_under[0] + 1;
        end
        check("under_sat",       32'(o_under), 32'(mdl_under[0]));
        check("under_laser_end", 32'(o_laser), 32'(mdl_laser[0]));
        check("under_no_cs",     32'(cs_falls), 32'(cf0));
        check("under_busy",      32'(o_busy), 32'd0);
        rx_q.delete();

        // back-to-back points at a 1700-cycle strobe period
        for (int i = 0; i < 5; i++) begin
            qx.push_back(12'($urandom));
            qy.push_back(12'($urandom));
            ql.push_back(1'($urandom));
        end
        lt0 = ldac_t.size();
        while (qx.size() > 0) begin
            run_txn(qx.pop_front(), qy.pop_front(), ql.pop_front(), 0);
            repeat (1700 - (66 * 4 + 1)) tick();
        end
        check("b2b_ldac_count", 32'(ldac_t.size() - lt0), 32'd5);
        for (int i = lt0 + 1; i < ldac_t.size(); i++) begin
            check($sformatf("b2b_ldac_spacing%0d", i), 32'(int'(ldac_t[i] - ldac_t[i-1])), 32'd17000);
        end

        // boundary codes on the CLK_DIV=2 instance
        sel = 1;
        tick();
        rx_q.delete();
        run_txn(12'h000, 12'hFFF, 1'($urandom), 0);
        run_txn(12'($urandom), 12'($urandom), 1'($urandom), $urandom_range(1, 132));
        sel = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
